ii_rect_sum_reader: RTL and testbench
=====================================

II_RECT_SUM_READER -- requirements
Module: ii_rect_sum_reader

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- IMG_W, 160, image width in pixels.
- IMG_H, 120, image height in pixels.
- ADDR_W, 15, integral-image buffer address width.
- DATA_W, 20, integral-image word width.
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; the buffer read port is driven from this clock.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, 1, rectangle request valid.
- req_ready, out, 1, block can accept a request.
- req_x, in, 8, left column x0.
- req_y, in, 7, top row y0.
- req_w, in, 8, width in pixels.
- req_h, in, 7, height in pixels.
- ii_rd_addr, out, ADDR_W, buffer read address.
- ii_rddata, in, DATA_W, buffer read data, valid 1 cycle after its address.
- sum_valid, out, 1, result valid.
- sum_ready, in, 1, downstream accepts the result.
- sum, out, DATA_W, rectangle pixel sum.
- sum_err, out, 1, request was out of range.

Function
REQ-003 The block SHALL be the reader of the integral image that the capture path writes: word at address y*IMG_W+x = sum of pixels (0..x, 0..y).
REQ-004 States SHALL be IDLE, CHECK, RD_D, RD_B, RD_C, RD_A, DRAIN, DONE.
REQ-005 req_ready SHALL be 1 only in IDLE; a handshake occurs when req_valid and req_ready are both 1, and the request fields SHALL be registered on that cycle (cycle 0).
REQ-006 CHECK (cycle 1) SHALL compute x1=x0+w-1 and y1=y0+h-1 at 9-bit width; the request is an error if w==0, h==0, x0+w>IMG_W or y0+h>IMG_H.
REQ-007 On error, the block SHALL go CHECK->DONE with sum=0, sum_err=1, issue no reads, and assert sum_valid at cycle 2.
REQ-008 Otherwise the block SHALL drive ii_rd_addr on cycles 2..5 with D=(x1,y1), B=(x1,y0-1), C=(x0-1,y1), A=(x0-1,y0-1); each address is row*IMG_W+col.
REQ-009 Data SHALL be captured on cycles 3..6 (one-cycle read latency) into a 21-bit signed accumulator: +D, -B, -C, +A.
REQ-010 A corner with y0==0 (B, A) or x0==0 (C, A) SHALL contribute 0; its slot is still consumed, so latency is fixed.
REQ-011 For valid requests sum_valid SHALL rise at cycle 7 with sum = accumulator[DATA_W-1:0] and sum_err=0.
REQ-012 In DONE, sum, sum_err and sum_valid SHALL hold until sum_valid and sum_ready are both 1; the block then returns to IDLE on the next cycle.
REQ-013 Back-to-back operation: the earliest next handshake SHALL be the cycle after the result handshake; throughput is one request per 8 cycles at full rate.
REQ-014 ii_rd_addr SHALL hold its last value outside RD_* states.
REQ-015 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-016 While rst=1 at a clk edge: state=IDLE, req_ready=0 during reset and 1 on the first cycle after, sum_valid=0, sum=0, sum_err=0, ii_rd_addr=0, accumulator=0.
REQ-017 Reset asserted mid-operation SHALL abort the request with no result produced; the next request after reset SHALL be processed normally.

Verification
REQ-018 The bench SHALL model the buffer as a 1-cycle-latency synchronous RAM holding an all-ones image, ii(x,y)=(x+1)(y+1), and SHALL cover these scenarios:
- V1: req (10,20,8,4) -> sum=32, sum_err=0, sum_valid at cycle 7, addresses 3697, 3057, 3689, 3049 in order.
- V2: req (0,0,160,120) -> sum=19200; only D (addr 19199) contributes.
- V3: req (0,5,3,2) -> sum=6; x0==0 corners zeroed.
- V4: req (159,119,1,1) -> sum=1; req (150,0,11,1) -> sum=0, sum_err=1, sum_valid at cycle 2; req w=0 -> sum_err=1.
- V5: sum_ready held low 5 cycles -> sum, sum_err and sum_valid stable, req_ready=0, new req_valid ignored.
- V6: rst pulsed at cycle 4 -> no sum_valid for that request; a following request (1,1,2,2) -> sum=4.

Source files
------------

// File: rtl/ii_rect_sum_reader.sv
// Integral-image rectangle reader: fetches the four corner words D, B, C, A of a
// requested rectangle and returns D - B - C + A with a fixed 7-cycle latency.
module ii_rect_sum_reader #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        req_x,
    input  logic [6:0]        req_y,
    input  logic [7:0]        req_w,
    input  logic [6:0]        req_h,
    output logic [ADDR_W-1:0] ii_rd_addr,
    input  logic [DATA_W-1:0] ii_rddata,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic [DATA_W-1:0] sum,
    output logic              sum_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_RD_D  = 3'd2;
    localparam logic [2:0] S_RD_B  = 3'd3;
    localparam logic [2:0] S_RD_C  = 3'd4;
    localparam logic [2:0] S_RD_A  = 3'd5;
    localparam logic [2:0] S_DRAIN = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam int         ACC_W  = DATA_W + 1;
    localparam logic [8:0] IMG_W9 = 9'(IMG_W);
    localparam logic [8:0] IMG_H9 = 9'(IMG_H);

    logic [2:0]               state_q, state_d;
    logic [7:0]               x0_q, x0_d;
    logic [6:0]               y0_q, y0_d;
    logic [7:0]               w_q, w_d;
    logic [6:0]               h_q, h_d;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]        sum_q, sum_d;
    logic                     sum_err_q, sum_err_d;

    logic [8:0]               x_end, y_end, x1, y1, xm1, ym1;
    logic                     x_zero, y_zero, req_bad;
    logic signed [ACC_W-1:0]  rd_ext;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [8:0] row, input logic [8:0] col);
        return ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
    endfunction

    always_comb begin
        x_end   = {1'b0, x0_q} + {1'b0, w_q};
        y_end   = {2'b00, y0_q} + {2'b00, h_q};
        x1      = x_end - 9'd1;
        y1      = y_end - 9'd1;
        xm1     = {1'b0, x0_q} - 9'd1;
        ym1     = {2'b00, y0_q} - 9'd1;
        x_zero  = (x0_q == '0);
        y_zero  = (y0_q == '0);
        req_bad = (w_q == '0) || (h_q == '0) || (x_end > IMG_W9) || (y_end > IMG_H9);
        rd_ext  = $signed({1'b0, ii_rddata});
    end

    // Data returned in each RD_*/DRAIN state belongs to the address issued one
    // state earlier; zeroed corners keep their slot but hold the address and
    // leave the accumulator untouched.
    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        w_d       = w_q;
        h_d       = h_q;
        rd_addr_d = rd_addr_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        sum_err_d = sum_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    x0_d    = req_x;
                    y0_d    = req_y;
                    w_d     = req_w;
                    h_d     = req_h;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                acc_d = '0;
                if (req_bad) begin
                    sum_d     = '0;
                    sum_err_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    rd_addr_d = addr_of(y1, x1);
                    state_d   = S_RD_D;
                end
            end
            S_RD_D: begin
                if (!y_zero) rd_addr_d = addr_of(ym1, x1);
                state_d = S_RD_B;
            end
            S_RD_B: begin
                acc_d = rd_ext;
                if (!x_zero) rd_addr_d = addr_of(y1, xm1);
                state_d = S_RD_C;
            end
            S_RD_C: begin
                if (!y_zero) acc_d = acc_q - rd_ext;
                if (!(x_zero || y_zero)) rd_addr_d = addr_of(ym1, xm1);
                state_d = S_RD_A;
            end
            S_RD_A: begin
                if (!x_zero) acc_d = acc_q - rd_ext;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!(x_zero || y_zero)) acc_d = acc_q + rd_ext;
                sum_d     = acc_d[DATA_W-1:0];
                sum_err_d = 1'b0;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (sum_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            rd_addr_q <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
            sum_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            w_q       <= w_d;
            h_q       <= h_d;
            rd_addr_q <= rd_addr_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            sum_err_q <= sum_err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign sum_valid  = (state_q == S_DONE);
    assign ii_rd_addr = rd_addr_q;
    assign sum        = sum_q;
    assign sum_err    = sum_err_q;

endmodule

// File: tb/tb_ii_rect_sum_reader.sv
// Bench for ii_rect_sum_reader: synchronous 1-cycle RAM holding an integral image,
// directed corner cases plus random rectangles checked against a pixel-sum model.
module tb_ii_rect_sum_reader;

    localparam int IMG_W = 160;
    localparam int IMG_H = 120;
    localparam int NPIX  = IMG_W * IMG_H;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_x;
    logic [6:0]  req_y;
    logic [7:0]  req_w;
    logic [6:0]  req_h;
    logic [14:0] ii_rd_addr;
    logic [19:0] ii_rddata;
    logic        sum_valid;
    logic        sum_ready;
    logic [19:0] sum;
    logic        sum_err;

    int          pix [NPIX];
    logic [19:0] ii_mem [NPIX];
    int          addr_seen [4];
    int          n_assert = 0;
    int          n_fail   = 0;

    ii_rect_sum_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(15), .DATA_W(20)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
        .ii_rd_addr(ii_rd_addr), .ii_rddata(ii_rddata),
        .sum_valid(sum_valid), .sum_ready(sum_ready),
        .sum(sum), .sum_err(sum_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        ii_rddata <= (int'(ii_rd_addr) < NPIX) ? ii_mem[ii_rd_addr] : 20'hFFFFF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic build_image(input bit ones);
        int run [IMG_W];
        for (int x = 0; x < IMG_W; x++) run[x] = 0;
        for (int y = 0; y < IMG_H; y++) begin
            int row = 0;
            for (int x = 0; x < IMG_W; x++) begin
                pix[y*IMG_W+x] = ones ? 1 : int'($urandom_range(0, 15));
                row += pix[y*IMG_W+x];
                run[x] += row;
                ii_mem[y*IMG_W+x] = 20'(run[x]);
            end
        end
    endtask

    function automatic bit ref_err(input int x, input int y, input int w, input int h);
        return (w == 0) || (h == 0) || (x + w > IMG_W) || (y + h > IMG_H);
    endfunction

    function automatic int ref_sum(input int x, input int y, input int w, input int h);
        int s = 0;
        if (ref_err(x, y, w, h)) return 0;
        for (int r = y; r < y + h; r++)
            for (int c = x; c < x + w; c++)
                s += pix[r*IMG_W+c];
        return s & 32'hFFFFF;
    endfunction

    task automatic junk_fields();
        req_x = 8'($urandom);
        req_y = 7'($urandom);
        req_w = 8'($urandom);
        req_h = 7'($urandom);
    endtask

    task automatic run_req(input string tag, input int x, input int y, input int w, input int h,
                           input int stall, input bit exp_err, input int exp_sum);
        int cyc = 0;
        logic [19:0] held_sum;
        logic        held_err;
        while (!req_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_x = 8'(x); req_y = 7'(y); req_w = 8'(w); req_h = 7'(h);
        @(posedge clk); #1;
        req_valid = 1'b0;
        junk_fields();
        cyc = 1;
        chk({tag, " busy_ready"}, 32'(req_ready), 32'd0);
        for (int i = 0; i < 4; i++) addr_seen[i] = -1;
        while (!sum_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
            if (cyc >= 2 && cyc <= 5) addr_seen[cyc-2] = int'(ii_rd_addr);
        end
        chk({tag, " latency"}, 32'(cyc), exp_err ? 32'd2 : 32'd7);
        chk({tag, " sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, " err"}, 32'(sum_err), 32'(exp_err));
        held_sum = sum;
        held_err = sum_err;
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1;
            junk_fields();
            @(posedge clk); #1;
            chk({tag, " hold_valid"}, 32'(sum_valid), 32'd1);
            chk({tag, " hold_sum"}, 32'(sum), 32'(held_sum));
            chk({tag, " hold_err"}, 32'(sum_err), 32'(held_err));
            chk({tag, " hold_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        sum_ready = 1'b1;
        @(posedge clk); #1;
        sum_ready = 1'b0;
        chk({tag, " released"}, 32'(sum_valid), 32'd0);
        chk({tag, " idle_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic run_model(input string tag, input int x, input int y, input int w, input int h,
                             input int stall);
        run_req(tag, x, y, w, h, stall, ref_err(x, y, w, h), ref_sum(x, y, w, h));
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; sum_ready = 1'b0;
        req_x = '0; req_y = '0; req_w = '0; req_h = '0;
        build_image(1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst ready", 32'(req_ready), 32'd0);
        chk("rst valid", 32'(sum_valid), 32'd0);
        chk("rst sum", 32'(sum), 32'd0);
        chk("rst err", 32'(sum_err), 32'd0);
        chk("rst addr", 32'(ii_rd_addr), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst ready", 32'(req_ready), 32'd1);

        // V1
        run_req("v1", 10, 20, 8, 4, 0, 1'b0, 32);
        chk("v1 addr_d", 32'(addr_seen[0]), 32'd3697);
        chk("v1 addr_b", 32'(addr_seen[1]), 32'd3057);
        chk("v1 addr_c", 32'(addr_seen[2]), 32'd3689);
        chk("v1 addr_a", 32'(addr_seen[3]), 32'd3049);
        // V2, V3
        run_req("v2", 0, 0, 160, 120, 0, 1'b0, 19200);
        chk("v2 addr_d", 32'(addr_seen[0]), 32'd19199);
        run_req("v3", 0, 5, 3, 2, 0, 1'b0, 6);
        // V4
        run_req("v4 corner", 159, 119, 1, 1, 0, 1'b0, 1);
        run_req("v4 xover", 150, 0, 11, 1, 0, 1'b1, 0);
        run_req("v4 w0", 5, 5, 0, 3, 0, 1'b1, 0);
        run_req("v4 h0", 5, 5, 3, 0, 0, 1'b1, 0);
        run_req("v4 yover", 0, 100, 4, 21, 0, 1'b1, 0);
        // V5
        run_req("v5 stall", 3, 4, 5, 6, 5, 1'b0, 30);
        run_req("v5 next", 2, 2, 2, 3, 0, 1'b0, 6);

        // V6: reset in the middle of a request
        while (!req_ready) begin @(posedge clk); #1; end
        req_valid = 1'b1; req_x = 8'd10; req_y = 7'd10; req_w = 8'd5; req_h = 7'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("v6 rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("v6 no_result", 32'(sum_valid), 32'd0);
        end
        chk("v6 addr_cleared", 32'(ii_rd_addr), 32'd0);
        chk("v6 sum_cleared", 32'(sum), 32'd0);
        run_req("v6 after", 1, 1, 2, 2, 0, 1'b0, 4);

        // Random rectangles over a random image
        build_image(1'b0);
        for (int n = 0; n < 40; n++) begin
            int x, y, w, h;
            x = int'($urandom_range(0, IMG_W - 1));
            y = int'($urandom_range(0, IMG_H - 1));
            if ($urandom_range(0, 9) == 0) begin
                w = int'($urandom_range(0, 255));
                h = int'($urandom_range(0, 127));
            end else begin
                w = int'($urandom_range(1, IMG_W - x));
                h = int'($urandom_range(1, IMG_H - y));
            end
            run_model("rand", x, y, w, h, int'($urandom_range(0, 3)));
        end
        run_model("rand full", 0, 0, 160, 120, 1);
        run_model("rand edge", 159, 0, 1, 120, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the end (observed hang, required finish)");
        $fatal(1, "timeout");
    end

endmodule
